msrv32_decode_imm_sequencer: RTL and testbench

//  Decode-stage front end between fetch and the rest of decode. Accepts fetched instructions on a

---
 rtl/msrv32_decode_imm_sequencer.sv | 172 +++++++++++++++++
 tb/tb_msrv32_decode_imm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_decode_imm_sequencer.sv
// Decode-stage front end: classifies the fetched opcode, builds its immediate,
// and holds up to two decoded entries (head + skid) so that decode always
// sees registered operands while fetch runs at full throughput.

// Immediate generator: assembles the 32-bit immediate for a given imm_type code.
module msrv32_imm_generator (
  input  logic [31:7] instr_i,
  input  logic [2:0]  imm_type_i,
  output logic [31:0] imm_o
);

  // Pure bit-shuffle per instruction format; CSR register forms reuse the I layout.
  always_comb begin
    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    case (imm_type_i)
      3'b010:  imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'b011:  imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      3'b100:  imm_o = {instr_i[31:12], 12'b0};
      3'b101:  imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      3'b110:  imm_o = {27'b0, instr_i[19:15]};
      default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    endcase
  end

endmodule

module msrv32_decode_imm_sequencer #(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16,
  parameter bit ILLEGAL_EN = 1'b1
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [31:0]      instr_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             flush_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [31:0]      instr_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [31:0]      imm_out,
  output logic [2:0]       imm_type_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  state_t            state_q;
  logic [31:0]       h_instr_q, s_instr_q;
  logic [PC_W-1:0]   h_pc_q, s_pc_q;
  logic [31:0]       h_imm_q, s_imm_q;
  logic [2:0]        h_type_q, s_type_q;
  logic              h_ill_q, s_ill_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [2:0]        type_d;
  logic              unknown_d;
  logic              illegal_d;
  logic [31:0]       imm_d;
  logic              accept;
  logic              emit;

  // Opcode classification on the input side, ahead of the registers.
  always_comb begin
    type_d    = 3'b000;
    unknown_d = 1'b0;
    case (instr_in[6:0])
      7'b0000011, 7'b0010011, 7'b0001111, 7'b0110011: type_d = 3'b000;
      7'b1100111:             type_d = 3'b001;
      7'b0100011:             type_d = 3'b010;
      7'b1100011:             type_d = 3'b011;
      7'b0110111, 7'b0010111: type_d = 3'b100;
      7'b1101111:             type_d = 3'b101;
      7'b1110011:             type_d = instr_in[14] ? 3'b110 : 3'b111;
      default:                unknown_d = 1'b1;
    endcase
    illegal_d = unknown_d & ILLEGAL_EN;
  end

  msrv32_imm_generator u_imm_gen (
    .instr_i    (instr_in[31:7]),
    .imm_type_i (type_d),
    .imm_o      (imm_d)
  );

  // Ready depends on state only, so out_ready_in never reaches in_ready_out.
  assign in_ready_out  = (state_q != ST_TWO);
  assign out_valid_out = (state_q != ST_EMPTY);
  assign accept        = in_valid_in & in_ready_out;
  assign emit          = out_valid_out & out_ready_in;

  // Head/skid FSM with the back-pressure counter; flush overrides the next state.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q     <= ST_EMPTY;
      h_instr_q   <= '0;
      h_pc_q      <= '0;
      h_imm_q     <= '0;
      h_type_q    <= '0;
      h_ill_q     <= 1'b0;
      s_instr_q   <= '0;
      s_pc_q      <= '0;
      s_imm_q     <= '0;
      s_type_q    <= '0;
      s_ill_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid_out && !out_ready_in && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            h_instr_q <= instr_in;
            h_pc_q    <= pc_in;
            h_imm_q   <= imm_d;
            h_type_q  <= type_d;
            h_ill_q   <= illegal_d;
            state_q   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            h_instr_q <= instr_in;
            h_pc_q    <= pc_in;
            h_imm_q   <= imm_d;
            h_type_q  <= type_d;
            h_ill_q   <= illegal_d;
          end else if (accept) begin
            s_instr_q <= instr_in;
            s_pc_q    <= pc_in;
            s_imm_q   <= imm_d;
            s_type_q  <= type_d;
            s_ill_q   <= illegal_d;
            state_q   <= ST_TWO;
          end else if (emit) begin
            state_q   <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            h_instr_q <= s_instr_q;
            h_pc_q    <= s_pc_q;
            h_imm_q   <= s_imm_q;
            h_type_q  <= s_type_q;
            h_ill_q   <= s_ill_q;
            state_q   <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (flush_in)
        state_q <= ST_EMPTY;
    end
  end

  assign instr_out     = h_instr_q;
  assign pc_out        = h_pc_q;
  assign imm_out       = h_imm_q;
  assign imm_type_out  = h_type_q;
  assign illegal_out   = h_ill_q;
  assign stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_msrv32_decode_imm_sequencer.sv
// Bench for msrv32_decode_imm_sequencer: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_msrv32_decode_imm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, illegal;
  logic [31:0] instr_o, pc_o, imm_o;
  logic [2:0]  type_o;
  logic [15:0] stall_cnt;

  logic        in_ready1, out_valid1, illegal1;
  logic [31:0] instr_o1, pc_o1, imm_o1;
  logic [2:0]  type_o1;
  logic [15:0] stall_cnt1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  msrv32_decode_imm_sequencer #(.PC_W(32), .CNT_W(16), .ILLEGAL_EN(1'b1)) u0 (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .in_valid_in            (in_valid),
    .in_ready_out           (in_ready),
    .instr_in               (instr),
    .pc_in                  (pc),
    .flush_in               (flush),
    .out_valid_out          (out_valid),
    .out_ready_in           (out_ready),
    .instr_out              (instr_o),
    .pc_out                 (pc_o),
    .imm_out                (imm_o),
    .imm_type_out           (type_o),
    .illegal_out            (illegal),
    .stall_cnt_out          (stall_cnt)
  );

  msrv32_decode_imm_sequencer #(.PC_W(32), .CNT_W(16), .ILLEGAL_EN(1'b0)) u1 (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .in_valid_in            (in_valid),
    .in_ready_out           (in_ready1),
    .instr_in               (instr),
    .pc_in                  (pc),
    .flush_in               (flush),
    .out_valid_out          (out_valid1),
    .out_ready_in           (out_ready),
    .instr_out              (instr_o1),
    .pc_out                 (pc_o1),
    .imm_out                (imm_o1),
    .imm_type_out           (type_o1),
    .illegal_out            (illegal1),
    .stall_cnt_out          (stall_cnt1)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_cnt = '0;
  bit          m_acc, m_emt;

  // Reference decode: format rules written as shifts and masks on the whole word.
  function automatic ent_t model_decode(logic [31:0] ins, logic [31:0] p);
    ent_t e;
    logic signed [31:0] s;
    logic [31:0] ii, sign;
    s    = ins;
    ii   = s >>> 20;
    sign = s >>> 31;
    e.instr = ins;
    e.pc    = p;
    e.ill   = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h0F, 7'h33: e.ty = 3'd0;
      7'h67:        e.ty = 3'd1;
      7'h23:        e.ty = 3'd2;
      7'h63:        e.ty = 3'd3;
      7'h37, 7'h17: e.ty = 3'd4;
      7'h6F:        e.ty = 3'd5;
      7'h73:        e.ty = ins[14] ? 3'd6 : 3'd7;
      default: begin e.ty = 3'd0; e.ill = 1'b1; end
    endcase
    case (e.ty)
      3'd2: e.imm = (ii & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
      3'd3: e.imm = (sign & 32'hFFFF_F000) | (((ins >> 7) & 32'h1) << 11) |
                    (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      3'd4: e.imm = ins & 32'hFFFF_F000;
      3'd5: e.imm = (sign & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      3'd6: e.imm = (ins >> 15) & 32'h1F;
      default: e.imm = ii;
    endcase
    return e;
  endfunction

  // Model: an at-most-two-deep FIFO of decoded entries plus a stall counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = '0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_emt = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready && (m_cnt != 16'hFFFF))
        m_cnt = m_cnt + 16'd1;
      if (flush) begin
        q.delete();
      end else begin
        if (m_emt) void'(q.pop_front());
        if (m_acc) q.push_back(model_decode(instr, pc));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("u1_out_valid", out_valid1, q.size() != 0);
      if (q.size() > 0) begin
        chk("instr_out", instr_o, q[0].instr);
        chk("pc_out", pc_o, q[0].pc);
        chk("imm_out", imm_o, q[0].imm);
        chk("imm_type", type_o, q[0].ty);
        chk("illegal", illegal, q[0].ill);
        chk("u1_instr", instr_o1, q[0].instr);
        chk("u1_imm", imm_o1, q[0].imm);
        chk("u1_illegal_off", illegal1, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_imm"}, imm_o, 32'h0);
    chk({tag, "_type"}, type_o, 3'd0);
    chk({tag, "_illegal"}, illegal, 1'b0);
    chk({tag, "_stall"}, stall_cnt, 16'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_reset_vals("rst");
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: ADDI then LUI at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1; instr = 32'hFFF0_0093; pc = 32'h100;
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_addi_imm", imm_o, 32'hFFFF_FFFF);
    chk("t1_addi_type", type_o, 3'd0);
    instr = 32'h1234_50B7; pc = 32'h104;
    tick();
    chk("t1_lui_imm", imm_o, 32'h1234_5000);
    chk("t1_lui_type", type_o, 3'd4);
    chk("t1_lui_ill", illegal, 1'b0);
    chk("t1_lui_pc", pc_o, 32'h104);
    in_valid = 1'b0;
    tick();
    chk("t1_drained", out_valid, 1'b0);

    // 2: back-pressure with BEQ, JAL, STORE
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'hFE00_0EE3; pc = 32'h200;
    tick();
    chk("t2_ready_one", in_ready, 1'b1);
    instr = 32'h0080_006F; pc = 32'h204;
    tick();
    chk("t2_ready_two", in_ready, 1'b0);
    instr = 32'h0011_2023; pc = 32'h208;
    tick(); tick(); tick();
    out_ready = 1'b1;
    chk("t2_stall", stall_cnt, 16'd4);
    chk("t2_beq_imm", imm_o, 32'hFFFF_FFFC);
    chk("t2_beq_type", type_o, 3'd3);
    tick();
    chk("t2_jal_instr", instr_o, 32'h0080_006F);
    chk("t2_jal_imm", imm_o, 32'h0000_0008);
    chk("t2_jal_type", type_o, 3'd5);
    tick();
    chk("t2_st_pc", pc_o, 32'h208);
    chk("t2_st_type", type_o, 3'd2);
    in_valid = 1'b0;
    tick();
    chk("t2_stall_final", stall_cnt, 16'd4);
    chk("t2_empty", out_valid, 1'b0);

    // 3: CSR immediate and register forms
    in_valid = 1'b1; instr = 32'h3002_D073; pc = 32'h300;
    tick();
    chk("t3_csrrwi_imm", imm_o, 32'h0000_0005);
    chk("t3_csrrwi_type", type_o, 3'd6);
    instr = 32'h3002_9073; pc = 32'h304;
    tick();
    chk("t3_csrrw_type", type_o, 3'd7);
    in_valid = 1'b0;
    tick();

    // 4: flush while full, with a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0010_0093; pc = 32'h400;
    tick();
    instr = 32'h0020_0093; pc = 32'h404;
    tick();
    flush = 1'b1; instr = 32'h0030_0093; pc = 32'h408;
    tick();
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t4_no_ghost", out_valid, 1'b0);
    tick();

    // 5: unknown opcode
    in_valid = 1'b1; instr = 32'h0000_007F; pc = 32'h500;
    tick();
    chk("t5_ill", illegal, 1'b1);
    chk("t5_type", type_o, 3'd0);
    chk("t5_ill_disabled", illegal1, 1'b0);
    in_valid = 1'b0;
    tick();

    // 6a: reset asserted while full
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0050_0093; pc = 32'h600;
    tick();
    instr = 32'h0060_0093; pc = 32'h604;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_empty", out_valid, 1'b0);

    // 6b: back-to-back streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      instr = 32'h0000_0013 | (32'(k) << 20);
      pc    = 32'h700 + 32'(4 * k);
      tick();
      chk("t6_stream_instr", instr_o, 32'h0000_0013 | (32'(k) << 20));
      chk("t6_stream_imm", imm_o, 32'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("t6_stall_zero", stall_cnt, 16'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
